// File: rtl/chipdlin_axil_reg_arbiter.sv
// chipdlin_axil_reg_arbiter
//   Round-robin arbiter between two word-access requesters (host bridge and
//   LIN scheduler) sharing the CHIPDLIN S00_AXI register slave. A granted
//   req/we/addr/wdata/wstrb access is turned into a single AXI4-Lite master
//   transaction. The read data and response are returned with a one-cycle
//   ack pulse to the requester that was granted.
// Ports
//   ACLK, ARESETN        clock, async active-low reset
//   req/we/addr/wdata/wstrb  per-requester access (requester n in slice n)
//   ack                  one-cycle completion pulse per requester
//   rdata, resp          shared read data / BRESP-RRESP, valid with ack
//   m_axi_*              AXI4-Lite master port (AW, W, B, AR, R channels)
module chipdlin_axil_reg_arbiter #(
  parameter int          ADDR_W = 6,
  parameter int          DATA_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_W-1:0]     addr,
  input  logic [2*DATA_W-1:0]     wdata,
  input  logic [2*DATA_W/8-1:0]   wstrb,
  output logic [1:0]              ack,
  output logic [DATA_W-1:0]       rdata,
  output logic [1:0]              resp,
  output logic [ADDR_W-1:0]       m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_W-1:0]       m_axi_wdata,
  output logic [DATA_W/8-1:0]     m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_W-1:0]       m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_W-1:0]       m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, DONE} state_t;

  state_t              state;
  logic                last_grant;
  logic                grant;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_wstrb;

  logic                sel;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;
  logic                aw_ok;
  logic                w_ok;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    sel = 1'b0;
    if (req == 2'b11) sel = ~last_grant;
    else              sel = req[1];
    sel_we    = sel ? we[1] : we[0];
    sel_addr  = sel ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
    sel_wdata = sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    sel_wstrb = sel ? wstrb[2*STRB_W-1:STRB_W] : wstrb[STRB_W-1:0];
  end

  // A channel is finished once its VALID has already dropped, or it
  // handshakes this cycle; both may complete in the same cycle.
  assign aw_ok = !m_axi_awvalid || m_axi_awready;
  assign w_ok  = !m_axi_wvalid  || m_axi_wready;

  assign m_axi_awaddr = {lat_addr[ADDR_W-1:2], 2'b00};
  assign m_axi_araddr = {lat_addr[ADDR_W-1:2], 2'b00};
  assign m_axi_awprot = PROT;
  assign m_axi_arprot = PROT;
  assign m_axi_wdata  = lat_wdata;
  assign m_axi_wstrb  = lat_wstrb;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant         <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_wstrb     <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      ack           <= '0;
      rdata         <= '0;
      resp          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant      <= sel;
            last_grant <= sel;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_wstrb  <= sel_wstrb;
            if (sel_we) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD;
            end
          end
        end
        WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axi_bready <= 1'b1;
            state        <= WRESP;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            resp         <= m_axi_bresp;
            ack          <= grant ? 2'b10 : 2'b01;
            state        <= DONE;
          end
        end
        RD: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rdata        <= m_axi_rdata;
            resp         <= m_axi_rresp;
            ack          <= grant ? 2'b10 : 2'b01;
            state        <= DONE;
          end
        end
        DONE: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chipdlin_axil_reg_arbiter.sv
// Directed bench for chipdlin_axil_reg_arbiter with a behavioural AXI4-Lite
// slave (4 words, configurable AWREADY delay, read stall, RRESP error on 0x8)
// and a queue of expected completions checked whenever ack pulses.
module tb_chipdlin_axil_reg_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic                  ACLK = 1'b0;
  logic                  ARESETN = 1'b0;
  logic [1:0]            req = '0;
  logic [1:0]            we = '0;
  logic [2*ADDR_W-1:0]   addr = '0;
  logic [2*DATA_W-1:0]   wdata = '0;
  logic [7:0]            wstrb = '0;
  logic [1:0]            ack;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            resp;
  logic [ADDR_W-1:0]     awaddr, araddr;
  logic [2:0]            awprot, arprot;
  logic                  awvalid, awready, wvalid, wready;
  logic [DATA_W-1:0]     m_wdata;
  logic [3:0]            m_wstrb;
  logic [1:0]            bresp;
  logic                  bvalid, bready;
  logic                  arvalid, arready;
  logic [DATA_W-1:0]     s_rdata;
  logic [1:0]            rresp;
  logic                  rvalid, rready;

  chipdlin_axil_reg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROT(3'b000)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .ack(ack), .rdata(rdata), .resp(resp),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(s_rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0]  smem [4];
  int unsigned  aw_delay = 0;
  int unsigned  aw_cnt;
  bit           r_hold = 0;
  bit           err_en = 0;
  logic         got_aw, got_w, r_pend;
  logic [5:0]   s_awaddr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic [1:0]   r_idx;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = 1'b1;
  assign arready = 1'b1;

  always @(posedge ACLK or negedge ARESETN) begin
    logic aw_now, w_now;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    if (!ARESETN) begin
      aw_cnt <= 0; got_aw <= 0; got_w <= 0; r_pend <= 0;
      bvalid <= 0; bresp <= 0; rvalid <= 0; rresp <= 0; s_rdata <= 0;
    end else begin
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1; else aw_cnt <= 0;
      if (aw_now) begin got_aw <= 1; s_awaddr <= awaddr; end
      if (w_now)  begin got_w <= 1; s_wdata <= m_wdata; s_wstrb <= m_wstrb; end
      if (bvalid && bready) bvalid <= 0;
      if ((got_aw || aw_now) && (got_w || w_now)) begin
        wa = aw_now ? awaddr : s_awaddr;
        wd = w_now ? m_wdata : s_wdata;
        ws = w_now ? m_wstrb : s_wstrb;
        for (int b = 0; b < 4; b++)
          if (ws[b]) smem[wa[3:2]][8*b +: 8] <= wd[8*b +: 8];
        bvalid <= 1; bresp <= 2'b00; got_aw <= 0; got_w <= 0;
      end
      if (rvalid && rready) rvalid <= 0;
      if (arvalid && arready) begin
        r_idx <= araddr[3:2];
        if (r_hold) r_pend <= 1;
        else begin
          rvalid  <= 1;
          s_rdata <= smem[araddr[3:2]];
          rresp   <= (err_en && araddr[3:2] == 2'd2) ? 2'b10 : 2'b00;
        end
      end else if (r_pend && !r_hold) begin
        r_pend  <= 0;
        rvalid  <= 1;
        s_rdata <= smem[r_idx];
        rresp   <= (err_en && r_idx == 2'd2) ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- scoreboard and channel monitor ----------------
  typedef struct {int id; logic [31:0] data; logic [1:0] resp;} exp_t;
  exp_t sb[$];
  exp_t e;

  int   cyc = 0;
  int   aw_hi = 0, w_hi = 0, rise_bad = 0, addr_moved = 0, bready_early = 0;
  logic prev_aw = 0, prev_w = 0;
  logic [5:0] prev_awaddr = '0;
  logic [5:0] rise_awaddr = '0;

  always @(negedge ACLK) begin
    cyc++;
    if (awvalid) aw_hi++;
    if (wvalid)  w_hi++;
    if ((awvalid && !prev_aw) != (wvalid && !prev_w)) rise_bad++;
    if (awvalid && !prev_aw) rise_awaddr = awaddr;
    if (awvalid && prev_aw && awaddr !== prev_awaddr) addr_moved++;
    if (bready && (awvalid || wvalid)) bready_early++;
    prev_aw = awvalid; prev_w = wvalid; prev_awaddr = awaddr;
    if (ARESETN === 1'b1 && ack !== 2'b00) begin
      if (sb.size() == 0) chk("spurious_ack", {30'd0, ack}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack_id", {30'd0, ack}, (e.id == 1) ? 32'd2 : 32'd1);
        chk("resp", {30'd0, resp}, {30'd0, e.resp});
        chk("rdata", rdata, e.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] mem_model [4];
  logic [31:0] last_rd = '0;

  task automatic push_exp(input int id, input bit w, input logic [5:0] a, input logic [31:0] d);
    exp_t x;
    x.id = id;
    if (w) begin
      mem_model[a[3:2]] = d;
      x.data = last_rd; x.resp = 2'b00;
    end else begin
      x.data = mem_model[a[3:2]];
      x.resp = (err_en && a[3:2] == 2'd2) ? 2'b10 : 2'b00;
      last_rd = x.data;
    end
    sb.push_back(x);
  endtask

  task automatic access(input int id, input bit w, input logic [5:0] a,
                        input logic [31:0] d, input int exp_lat, input string tag);
    int n;
    bit got;
    n = 0; got = 0;
    push_exp(id, w, a, d);
    we[id] = w;
    addr[id*ADDR_W +: ADDR_W] = a;
    wdata[id*DATA_W +: DATA_W] = d;
    wstrb[id*4 +: 4] = 4'hF;
    req[id] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge ACLK); #1;
      n++;
      if (ack[id]) begin got = 1; break; end
    end
    chk({tag, "_acked"}, {31'd0, got}, 32'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, n, exp_lat);
    req[id] = 1'b0;
    @(posedge ACLK); #1;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(posedge ACLK); #1;
  endtask

  initial begin
    int base_rise, base_aw, base_w, base_mv, base_be;
    bit done;
    for (int i = 0; i < 4; i++) begin smem[i] = '0; mem_model[i] = '0; end
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_ack", {30'd0, ack}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {30'd0, resp}, 0);
    chk("rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 0);
    #1 ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // 1: R0 writes, always-ready slave
    base_rise = rise_bad;
    for (int i = 0; i < 4; i++)
      access(0, 1'b1, 6'(4*i), 32'(i + 1), 3, "t1_wr");
    chk("t1_aw_w_rise_together", rise_bad - base_rise, 0);

    // 2: R1 reads back
    for (int i = 0; i < 4; i++)
      access(1, 1'b0, 6'(4*i), 32'd0, 3, "t2_rd");

    // 3: simultaneous requests after reset, held high: strict alternation
    do_reset();
    last_rd = '0;
    for (int i = 0; i < 8; i++) push_exp(i % 2, 1'b0, (i % 2) ? 6'h4 : 6'h0, 32'd0);
    we = 2'b00;
    addr = {6'h4, 6'h0};
    req = 2'b11;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge ACLK); #1;
      if (sb.size() == 0) begin done = 1; break; end
    end
    req = 2'b00;
    chk("t3_all_served", {31'd0, done}, 1);
    @(posedge ACLK); #1;

    // 4: AWREADY 3 cycles late, WREADY immediate; addr bits [1:0] forced to 0
    aw_delay = 3;
    base_aw = aw_hi; base_w = w_hi; base_mv = addr_moved; base_be = bready_early;
    base_rise = rise_bad;
    access(0, 1'b1, 6'h6, 32'h5A5A_0002, 6, "t4_wr");
    chk("t4_awvalid_cycles", aw_hi - base_aw, 4);
    chk("t4_wvalid_cycles", w_hi - base_w, 1);
    chk("t4_awaddr_stable", addr_moved - base_mv, 0);
    chk("t4_bready_after_both", bready_early - base_be, 0);
    chk("t4_rise_together", rise_bad - base_rise, 0);
    chk("t4_awaddr_aligned", {26'd0, rise_awaddr}, 32'h4);
    aw_delay = 0;

    // 5: SLVERR on 0x8 forwarded, next access normal
    err_en = 1;
    access(0, 1'b0, 6'h8, 32'd0, 3, "t5_err_rd");
    err_en = 0;
    access(0, 1'b0, 6'h0, 32'd0, 3, "t5_next_rd");

    // 6: reset while waiting in RDATA
    r_hold = 1;
    push_exp(1, 1'b0, 6'hC, 32'd0);
    we[1] = 1'b0; addr[11:6] = 6'hC; req[1] = 1'b1;
    done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge ACLK); #1;
      if (rready) begin done = 1; break; end
    end
    chk("t6_reached_rdata", {31'd0, done}, 1);
    chk("t6_rdata_before", rdata, 32'h1);
    ARESETN = 1'b0;
    #1;
    chk("t6_rready_async", {31'd0, rready}, 0);
    chk("t6_ack_async", {30'd0, ack}, 0);
    chk("t6_rdata_async", rdata, 0);
    chk("t6_resp_async", {30'd0, resp}, 0);
    req[1] = 1'b0;
    sb.delete();
    last_rd = '0;
    r_hold = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(posedge ACLK); #1;
    access(1, 1'b0, 6'hC, 32'd0, 3, "t6_reissue");
    chk("t6_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
